// File: rtl/iob_mem_rd_pkg.sv
// Shared types and constants for the two-port memory streaming reader.
package iob_mem_rd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam int BUF_DEPTH = 2;
    localparam int PTR_W     = $clog2(BUF_DEPTH);
    localparam int OCC_W     = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/iob_mem_rd_buf2.sv
// Two-entry FIFO that holds read words until the stream consumer accepts them.
module iob_mem_rd_buf2
    import iob_mem_rd_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              flush,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic [OCC_W-1:0]  occ
);

    logic [DATA_W-1:0] store [BUF_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign out_valid = (occ != '0);
    assign out_data  = store[rd_ptr];
    assign pop_ok    = pop && (occ != '0);
    assign push_ok   = push && ((occ != OCC_W'(BUF_DEPTH)) || pop_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                store[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push_ok) begin
                store[wr_ptr] <= push_data;
                wr_ptr        <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            occ <= occ + OCC_W'(push_ok) - OCC_W'(pop_ok);
        end
    end

endmodule

// File: rtl/iob_2p_mem_rd_stream.sv
// Streaming reader for a two-port memory read port; sweeps a wrapping address range.
// Optional abort input enabled by defining IOB_MEM_RD_ABORT_EN.
module iob_2p_mem_rd_stream
    import iob_mem_rd_pkg::*;
#(
    parameter int R_DATA_W = 8,
    parameter int R_ADDR_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [R_ADDR_W-1:0] base_addr,
    input  logic [R_ADDR_W:0]   len,
    output logic                busy,
    output logic                done,
    output logic                mem_r_en,
    output logic [R_ADDR_W-1:0] mem_r_addr,
    input  logic [R_DATA_W-1:0] mem_r_data,
    output logic [R_DATA_W-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready
`ifdef IOB_MEM_RD_ABORT_EN
    ,
    input  logic                abort
`endif
);

    localparam int LVL_W = OCC_W + 1;

    state_t            state;
    state_t            state_nxt;
    logic [R_ADDR_W:0] remaining;
    logic              inflight;
    logic              issue;
    logic              pop;
    logic              abort_hit;
    logic [OCC_W-1:0]  occ;
    logic [LVL_W-1:0]  level;

`ifdef IOB_MEM_RD_ABORT_EN
    assign abort_hit = abort && ((state == RUN) || (state == DRAIN));
`else
    assign abort_hit = 1'b0;
`endif

    // Words the buffer will hold next cycle if nothing new is issued now.
    assign pop   = out_valid && out_ready;
    assign level = LVL_W'(occ) + LVL_W'(inflight) - LVL_W'(pop);

    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign mem_r_en = issue;

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                issue = (level < LVL_W'(2)) && !abort_hit;
                if (abort_hit) begin
                    state_nxt = DONE;
                end else if (issue && (remaining == (R_ADDR_W + 1)'(1))) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (abort_hit || (level == '0)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            mem_r_addr <= '0;
            remaining  <= '0;
            inflight   <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= issue;
            if ((state == IDLE) && start && (len != '0)) begin
                mem_r_addr <= base_addr;
                remaining  <= len;
            end else if (issue) begin
                mem_r_addr <= mem_r_addr + R_ADDR_W'(1);
                remaining  <= remaining - (R_ADDR_W + 1)'(1);
            end
        end
    end

    iob_mem_rd_buf2 #(
        .DATA_W(R_DATA_W)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .push     (inflight && !abort_hit),
        .push_data(mem_r_data),
        .pop      (pop),
        .flush    (abort_hit),
        .out_data (out_data),
        .out_valid(out_valid),
        .occ      (occ)
    );

endmodule

// File: tb/tb_iob_2p_mem_rd_stream.sv
// Directed bench for iob_2p_mem_rd_stream with a queue-based reference model.
module tb_iob_2p_mem_rd_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] base_addr;
    logic [4:0] len;
    logic       busy;
    logic       done;
    logic       mem_r_en;
    logic [3:0] mem_r_addr;
    logic [7:0] mem_r_data;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
`ifdef IOB_MEM_RD_ABORT_EN
    logic       abort;
`endif

    logic [7:0] mem [16];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int t0 = 0;

    // Command description handed from the stimulus to the model.
    int cmd_gen = 0;
    int cmd_base = 0;
    int cmd_len = 0;
    int flush_gen = 0;

    // Owned by the checker process.
    int seen_gen = 0;
    int seen_flush = 0;
    int exp_addr[$];
    int exp_data[$];
    int outst = 0;
    int issues = 0;
    int pops = 0;
    int busy_cnt = 0;
    int first_valid_rel = -1;
    int last_pop_rel = -1;
    int done_rel = -1;
    bit done_seen = 1'b0;
    int got_addr[16];
    int got_data[16];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'(32 + i);
    end

    always @(posedge clk) begin
        if (rst) mem_r_data <= '0;
        else if (mem_r_en) mem_r_data <= mem[mem_r_addr];
    end

    iob_2p_mem_rd_stream #(
        .R_DATA_W(8),
        .R_ADDR_W(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .mem_r_en  (mem_r_en),
        .mem_r_addr(mem_r_addr),
        .mem_r_data(mem_r_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef IOB_MEM_RD_ABORT_EN
        ,
        .abort     (abort)
`endif
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model and compare process.
    always @(negedge clk) begin
        int rel;
        int e;
        rel = cyc - t0;
        if (rst || (flush_gen != seen_flush)) begin
            seen_flush = flush_gen;
            exp_addr.delete();
            exp_data.delete();
            outst = 0;
        end
        if (cmd_gen != seen_gen) begin
            seen_gen = cmd_gen;
            exp_addr.delete();
            exp_data.delete();
            for (int i = 0; i < cmd_len; i++) begin
                exp_addr.push_back((cmd_base + i) % 16);
                exp_data.push_back(32 + ((cmd_base + i) % 16));
            end
            issues = 0;
            pops = 0;
            busy_cnt = 0;
            first_valid_rel = -1;
            last_pop_rel = -1;
            done_rel = -1;
            done_seen = 1'b0;
        end
        if (!rst) begin
            check("outstanding_le_2", int'(outst <= 2), 1);
            if (mem_r_en) begin
                if (issues < 16) got_addr[issues] = int'(mem_r_addr);
                issues++;
                if (exp_addr.size() == 0) check("unexpected_read", 1, 0);
                else begin
                    e = exp_addr.pop_front();
                    check("mem_r_addr", int'(mem_r_addr), e);
                end
            end
            if (out_valid && first_valid_rel < 0) first_valid_rel = rel;
            if (out_valid && out_ready) begin
                if (pops < 16) got_data[pops] = int'(out_data);
                pops++;
                last_pop_rel = rel;
                if (exp_data.size() == 0) check("unexpected_word", 1, 0);
                else begin
                    e = exp_data.pop_front();
                    check("out_data", int'(out_data), e);
                end
            end
            if (done && !done_seen) begin
                done_seen = 1'b1;
                done_rel = rel;
            end
            if (busy) busy_cnt++;
            outst = outst + int'(mem_r_en) - int'(out_valid && out_ready);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_cmd(input int b, input int l);
        start = 1'b1;
        base_addr = 4'(b);
        len = 5'(l);
        cmd_base = b;
        cmd_len = l;
        t0 = cyc;
        cmd_gen++;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input bit toggle);
        logic [3:0] pat;
        int i;
        pat = 4'b1001;
        i = 0;
        while (!done_seen && i < 300) begin
            if (toggle) out_ready = pat[i % 4];
            tick();
            i++;
        end
        if (!done_seen) check("done_timeout", 0, 1);
        out_ready = 1'b1;
        tick();
        check("model_drained", exp_data.size(), 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        base_addr = '0;
        len = '0;
        out_ready = 1'b1;
`ifdef IOB_MEM_RD_ABORT_EN
        abort = 1'b0;
`endif
        tick();
        tick();
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_mem_r_en", int'(mem_r_en), 0);
        check("rst_mem_r_addr", int'(mem_r_addr), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        rst = 1'b0;
        tick();

        // Full sweep, consumer always ready.
        begin_cmd(0, 16);
        wait_done(1'b0);
        check("full_pops", pops, 16);
        check("full_first_valid_cycle", first_valid_rel, 3);
        check("full_last_pop_cycle", last_pop_rel, 18);
        check("full_done_cycle", done_rel, 19);
        check("full_first_word", got_data[0], 32);
        check("full_last_word", got_data[15], 47);

        // Address wrap.
        begin_cmd(14, 4);
        wait_done(1'b0);
        check("wrap_addr0", got_addr[0], 14);
        check("wrap_addr1", got_addr[1], 15);
        check("wrap_addr2", got_addr[2], 0);
        check("wrap_addr3", got_addr[3], 1);
        check("wrap_word0", got_data[0], 46);
        check("wrap_word2", got_data[2], 32);
        check("wrap_word3", got_data[3], 33);

        // Zero-length command.
        begin_cmd(7, 0);
        wait_done(1'b0);
        tick();
        check("len0_issues", issues, 0);
        check("len0_done_cycle", done_rel, 1);
        check("len0_busy_cycles", busy_cnt, 1);

        // Back-pressure.
        begin_cmd(0, 8);
        wait_done(1'b1);
        check("bp_pops", pops, 8);
        check("bp_issues", issues, 8);
        check("bp_last_word", got_data[7], 39);

        // Start while busy is ignored.
        begin_cmd(3, 5);
        tick();
        tick();
        start = 1'b1;
        base_addr = 4'd9;
        len = 5'd2;
        tick();
        start = 1'b0;
        wait_done(1'b0);
        check("restart_pops", pops, 5);
        check("restart_issues", issues, 5);
        check("restart_first_word", got_data[0], 35);

        // Reset mid-command.
        begin_cmd(0, 16);
        for (int k = 0; k < 6; k++) tick();
        rst = 1'b1;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_mem_r_en", int'(mem_r_en), 0);
        check("midrst_mem_r_addr", int'(mem_r_addr), 0);
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_out_data", int'(out_data), 0);
        tick();
        rst = 1'b0;
        tick();
        begin_cmd(5, 2);
        wait_done(1'b0);
        check("postrst_pops", pops, 2);
        check("postrst_word0", got_data[0], 37);

`ifdef IOB_MEM_RD_ABORT_EN
        begin
            int g;
            begin_cmd(0, 8);
            g = 0;
            while (pops < 3 && g < 50) begin
                tick();
                g++;
            end
            abort = 1'b1;
            tick();
            abort = 1'b0;
            flush_gen++;
            check("abort_out_valid", int'(out_valid), 0);
            check("abort_done", int'(done), 1);
            tick();
            check("abort_idle", int'(busy), 0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/iob_2p_mem_rd_stream.md
# iob_2p_mem_rd_stream

Single-clock streaming reader for the read port of the team's two-port (asymmetric-width) memories. On a start command it sweeps a contiguous, wrap-around address range and issues one read-enable per word, absorbing the memory's 1-cycle read latency. Words are delivered on a valid/ready output stream, with a 2-entry buffer that provides back-pressure. It sits between a read-side memory port and any stream consumer, and is the read-side counterpart of the sequential writer used to fill these memories.

## Interface
- R_DATA_W, 8, memory read data width (bits)
- R_ADDR_W, 4, memory read address width
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  command strobe, sampled only in IDLE
- base_addr  in  R_ADDR_W  first read address
- len  in  R_ADDR_W+1  word count, 0..2^R_ADDR_W
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse at command completion
- mem_r_en  out  1  memory read enable
- mem_r_addr  out  R_ADDR_W  memory read address
- mem_r_data  in  R_DATA_W  memory read data, valid the cycle after mem_r_en
- out_data  out  R_DATA_W  stream data
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready; a transfer occurs when out_valid & out_ready
- abort  in  1  present only with IOB_MEM_RD_ABORT_EN

## Operation
- FSM: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on start with len != 0. Latch base_addr into the address counter and len into the remaining-issue counter.
  - IDLE -> DONE on start with len == 0; no reads are issued.
  - RUN -> DRAIN once the last read has been issued.
  - DRAIN -> DONE when the buffer is empty and nothing is in flight.
  - DONE -> IDLE unconditionally.
- mem_r_en = (state == RUN) & credit, where credit = (occ + inflight - pop) < 2.
  - occ: buffer occupancy, 0..2.
  - inflight: registered copy of the previous cycle's mem_r_en.
  - pop: out_valid & out_ready.
- mem_r_addr is the address counter. It increments on each issue and wraps modulo 2^R_ADDR_W (base 14, len 4 reads 14, 15, 0, 1).
- The buffer captures mem_r_data in the cycle where inflight = 1. Words leave in FIFO order. The credit rule guarantees the buffer never overflows.
- start while busy: ignored, with no effect on the running command.
- done is high only in DONE.
- Reset (asynchronous, also valid mid-command): state IDLE; all counters, occ and inflight cleared. Output reset values: busy=0, done=0, mem_r_en=0, mem_r_addr=0, out_valid=0, out_data=0.

## Timing
Cycle numbering is relative to the rising edge on which start is sampled (cycle 0).
- Cycle 1: mem_r_en=1, mem_r_addr=base_addr.
- Cycle 2: mem_r_data valid and captured.
- Cycle 3: out_valid=1 with the first word (start-to-first-word latency 3 cycles).
- Throughput: with out_ready held high, one word per cycle and no bubbles.
- With out_ready low: at most 2 words are outstanding (buffered plus in-flight), then mem_r_en drops.
- Completion: done pulses in the cycle after the final pop (the final pop empties the buffer, so DRAIN exits on that cycle). The next start is accepted in the cycle after done.
- len=0: DONE in cycle 1, IDLE in cycle 2.

## Configuration
- IOB_MEM_RD_ABORT_EN defined:
  - Adds the abort input.
  - abort in RUN or DRAIN: stop issuing, flush the buffer (out_valid=0 next cycle), discard any in-flight word, go to DONE, pulse done.
  - abort in IDLE or DONE: ignored.
- IOB_MEM_RD_ABORT_EN undefined: no abort port, and a command always runs to completion.

## Structure
- Package iob_mem_rd_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - localparam BUF_DEPTH = 2.
- Sub-module iob_mem_rd_buf2 is the 2-entry FIFO buffer.
  - Ports: push, push_data, pop, out_data, out_valid, occ, flush.
  - The top level contains the FSM, counters and credit logic.

## Test plan
- Memory preloaded with mem[i] = 32 + i, 8-bit words, depth 16. base 0, len 16, out_ready=1 -> outputs 32..47 in 16 consecutive cycles; first out_valid at cycle 3; done one cycle after the last pop.
- base 14, len 4 -> mem_r_addr sequence 14, 15, 0, 1; outputs 46, 47, 32, 33.
- len 0 -> no mem_r_en; done pulses in cycle 1; busy high in cycle 1 only.
- base 0, len 8, with out_ready toggling 1, 0, 0, 1 repeatedly -> outputs 32..39 in order, no loss or duplication, occ never exceeds 2.
- Second start asserted mid-command -> ignored; exactly len words are output.
- Reset pulsed mid-command -> all outputs 0 immediately. With IOB_MEM_RD_ABORT_EN, abort after 3 pops -> out_valid=0 next cycle and done pulses.
